// File: rtl/rv32i_run_ctrl.sv
// Run sequencer for the RV32I board core: start sync, core reset hold, halt/timeout detect.
// Optional RUN_CTRL_CYCLE_CNT_EN adds the cycle_cnt port with the last run length.
module rv32i_run_ctrl #(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int HALT_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic [31:0] pc,
  input  logic [31:0] gcd_result,
  output logic        core_rst_n,
  output logic        calc_start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result,
  output logic [15:0] led
`ifdef RUN_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] HALT_LAST = 32'(HALT_CYCLES - 1);
  localparam logic [31:0] TOUT_LIM  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] SAT       = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_START,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        btn_edge;
  logic [31:0] hold_cnt_q;
  logic [31:0] run_cnt_q;
  logic [31:0] stable_q;
  logic [31:0] prev_pc_q;
  logic [31:0] result_q;
  logic [31:0] run_nx;
  logic [31:0] stable_nx;
  logic        halt_hit;
  logic        tout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign btn_edge = sync2_q & ~sync3_q;

  // Halt/timeout look at the values this RUN cycle produces
  always_comb begin
    run_nx    = (run_cnt_q == SAT) ? run_cnt_q : run_cnt_q + 32'd1;
    stable_nx = 32'd0;
    if (pc == prev_pc_q)
      stable_nx = (stable_q == SAT) ? stable_q : stable_q + 32'd1;
    halt_hit  = (stable_nx >= HALT_LAST);
    tout_hit  = (run_nx >= TOUT_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_TOUT:
        if (btn_edge) state_d = S_HOLD;
      S_HOLD:
        if (hold_cnt_q >= HOLD_LAST) state_d = S_START;
      S_START:
        state_d = S_RUN;
      S_RUN:
        if (halt_hit)      state_d = S_DONE;
        else if (tout_hit) state_d = S_TOUT;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_rst_n = 1'b0;
    calc_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      S_HOLD:  busy = 1'b1;
      S_START: begin
        core_rst_n = 1'b1;
        calc_start = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        core_rst_n = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        core_rst_n = 1'b1;
        done       = 1'b1;
      end
      S_TOUT: begin
        core_rst_n = 1'b1;
        timeout    = 1'b1;
      end
      default: core_rst_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 32'd0;
      run_cnt_q  <= 32'd0;
      stable_q   <= 32'd0;
      prev_pc_q  <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      hold_cnt_q <= (state_q == S_HOLD) ? hold_cnt_q + 32'd1 : 32'd0;
      if (state_q == S_START) begin
        run_cnt_q <= 32'd0;
        stable_q  <= 32'd0;
        prev_pc_q <= SAT;
      end else if (state_q == S_RUN) begin
        run_cnt_q <= run_nx;
        stable_q  <= stable_nx;
        prev_pc_q <= pc;
        if (halt_hit)      result_q <= gcd_result;
        else if (tout_hit) result_q <= SAT;
      end
    end
  end

`ifdef RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt_q <= 32'd0;
    else if (state_q == S_RUN && (halt_hit || tout_hit))
      cycle_cnt_q <= run_nx;
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

  assign result = result_q;
  assign led    = result_q[15:0];

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Directed bench for rv32i_run_ctrl with a behavioural core model and a
// result scoreboard. Define RUN_CTRL_CYCLE_CNT_EN to also check cycle_cnt.
module tb_rv32i_run_ctrl;

  localparam int HOLD = 4;
  localparam int HALT = 4;
  localparam int TOUT = 64;

  typedef struct packed {
    logic [31:0] res;
    logic        d;
    logic        t;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [31:0] pc;
  logic [31:0] gcd_result = 32'd0;
  logic        core_rst_n;
  logic        calc_start;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] result;
  logic [15:0] led;
`ifdef RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  int   lim_v = 0;
  int   steps = 0;
  int   n_start = 0;
  int   n_hold = 0;
  exp_t sb[$];

  rv32i_run_ctrl #(
    .RST_HOLD_CYCLES(HOLD),
    .HALT_CYCLES(HALT),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn(start_btn),
    .pc(pc),
    .gcd_result(gcd_result),
    .core_rst_n(core_rst_n),
    .calc_start(calc_start),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .result(result),
    .led(led)
`ifdef RUN_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Core model: pc advances by 4 for lim_v cycles after reset, then sticks
  always @(posedge clk) begin
    if (!core_rst_n) begin
      pc    <= 32'd0;
      steps <= 0;
    end else if (steps < lim_v) begin
      pc    <= pc + 32'd4;
      steps <= steps + 1;
    end
  end

  always @(negedge clk) begin
    if (calc_start) n_start <= n_start + 1;
    if (busy && !core_rst_n) n_hold <= n_hold + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int lim, input logic [31:0] g);
    exp_t e;
    if (lim + HALT - 1 <= TOUT) begin
      e.res = g;
      e.d   = 1'b1;
      e.t   = 1'b0;
      e.cnt = 32'(lim + HALT - 1);
    end else begin
      e.res = 32'hFFFF_FFFF;
      e.d   = 1'b0;
      e.t   = 1'b1;
      e.cnt = 32'(TOUT);
    end
    return e;
  endfunction

  task automatic press();
    @(negedge clk);
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_busy_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_clr"}, {31'd0, done | timeout}, 32'd0);
  endtask

  task automatic run_and_check(input string tag, input int lim,
                               input logic [31:0] g, input bit mid_press);
    exp_t e;
    bit   fin = 1'b0;
    int   s0, h0;
    sb.push_back(predict(lim, g));
    lim_v      = lim;
    gcd_result = g;
    s0 = n_start;
    h0 = n_hold;
    press();
    wait_busy(tag);
    if (mid_press) begin
      repeat (6) @(negedge clk);
      press();
    end
    for (int i = 0; i < 300; i++) begin
      if (done || timeout) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    e = sb.pop_front();
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e.d});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, e.t});
    chk({tag, "_led"}, {16'd0, led}, {16'd0, e.res[15:0]});
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
    chk({tag, "_starts"}, 32'(n_start - s0), 32'd1);
    chk({tag, "_hold_cyc"}, 32'(n_hold - h0), 32'(HOLD));
`ifdef RUN_CTRL_CYCLE_CNT_EN
    chk({tag, "_cycle_cnt"}, cycle_cnt, e.cnt);
`endif
    repeat (10) @(negedge clk);
    chk({tag, "_sticky"}, {30'd0, done, timeout}, {30'd0, e.d, e.t});
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_core_on"}, {31'd0, core_rst_n}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_core", {31'd0, core_rst_n}, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_state",
          {28'd0, core_rst_n, busy, done, timeout}, 32'd0);
      chk("idle_led", {16'd0, led}, 32'd0);
    end

    run_and_check("halt", 10, 32'd6, 1'b0);
    run_and_check("tout", 1000, 32'd7, 1'b0);
    run_and_check("halt2", 3, 32'd21, 1'b0);
    run_and_check("busy_press", 5, 32'd9, 1'b1);
    run_and_check("repress", 2, 32'h0001_2345, 1'b0);

    lim_v      = 1000;
    gcd_result = 32'd55;
    press();
    wait_busy("arst");
    repeat (12) @(negedge clk);
    chk("arst_in_run", {30'd0, busy, core_rst_n}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs",
        {27'd0, core_rst_n, calc_start, busy, done, timeout}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_led", {16'd0, led}, 32'd0);
`ifdef RUN_CTRL_CYCLE_CNT_EN
    chk("arst_cycle_cnt", cycle_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_idle",
        {28'd0, core_rst_n, busy, done, timeout}, 32'd0);

    run_and_check("tie", 61, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
